// File: rtl/axis_deheaderizer_pkg.sv
// Shared definitions for axis_deheaderizer: FSM encoding, header field offsets
// and the header-fits-in-TDATA check.
package axis_deheaderizer_pkg;

  typedef enum logic {
    HDR  = 1'b0,
    BODY = 1'b1
  } state_t;

  localparam int DEST_LSB = 0;

  function automatic int id_lsb(input int dest_w);
    return dest_w;
  endfunction

  function automatic int user_lsb(input int dest_w, input int id_w);
    return dest_w + id_w;
  endfunction

  function automatic bit hdr_fits(input int data_w, input int dest_w,
                                  input int id_w, input int user_w);
    return (dest_w + id_w + user_w) <= data_w;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry registered skid buffer; in_ready is registered and means "skid
// entry empty", so upstream never sees a combinational path from out_ready.
module axis_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  assign in_ready = !skid_valid;

  // Handshake: a beat moves on in_valid && in_ready, and on out_valid && out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/axis_deheaderizer.sv
// Strips a leading header flit from each packet and replays its TDEST/TID/TUSER
// on every body flit. Optional err_cnt under AXIS_DEHEADERIZER_ERR_CNT_EN.
module axis_deheaderizer
  import axis_deheaderizer_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 16,
  parameter int ID_WIDTH   = 16,
  parameter int USER_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   hdr_TDATA,
  input  logic                    hdr_TVALID,
  output logic                    hdr_TREADY,
  input  logic [DATA_WIDTH/8-1:0] hdr_TKEEP,
  input  logic                    hdr_TLAST,
  output logic [DATA_WIDTH-1:0]   sides_TDATA,
  output logic                    sides_TVALID,
  input  logic                    sides_TREADY,
  output logic [DATA_WIDTH/8-1:0] sides_TKEEP,
  output logic                    sides_TLAST,
  output logic [DEST_WIDTH-1:0]   sides_TDEST,
  output logic [ID_WIDTH-1:0]     sides_TID,
  output logic [USER_WIDTH-1:0]   sides_TUSER,
`ifdef AXIS_DEHEADERIZER_ERR_CNT_EN
  output logic [15:0]             err_cnt,
`endif
  output state_t                  dbg_state
);

  localparam int KEEP_W   = DATA_WIDTH / 8;
  localparam int ID_LSB   = id_lsb(DEST_WIDTH);
  localparam int USER_LSB = user_lsb(DEST_WIDTH, ID_WIDTH);
  localparam int PW = DATA_WIDTH + KEEP_W + 1 + DEST_WIDTH + ID_WIDTH + USER_WIDTH;

  if (!hdr_fits(DATA_WIDTH, DEST_WIDTH, ID_WIDTH, USER_WIDTH)) begin : g_hdr_check
    $error("axis_deheaderizer: DEST_WIDTH+ID_WIDTH+USER_WIDTH exceeds DATA_WIDTH");
  end

  state_t                state, state_n;
  logic [DEST_WIDTH-1:0] dest_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [USER_WIDTH-1:0] user_q;
  logic                  skid_in_ready;
  logic                  accept;
  logic [PW-1:0]         in_payload;
  logic [PW-1:0]         out_payload;

  // Headers are always taken; body flits only when the skid entry is free.
  assign hdr_TREADY = !rst && ((state == HDR) || skid_in_ready);
  assign accept     = hdr_TVALID && hdr_TREADY;
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (rst) state <= HDR;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      HDR:  if (accept && !hdr_TLAST) state_n = BODY;
      BODY: if (accept && hdr_TLAST)  state_n = HDR;
      default: state_n = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dest_q <= '0;
      id_q   <= '0;
      user_q <= '0;
    end else if (state == HDR && accept && !hdr_TLAST) begin
      dest_q <= hdr_TDATA[DEST_LSB +: DEST_WIDTH];
      id_q   <= hdr_TDATA[ID_LSB +: ID_WIDTH];
      user_q <= hdr_TDATA[USER_LSB +: USER_WIDTH];
    end
  end

  // Sideband travels with each flit so a following header cannot alter a buffered tail.
  assign in_payload = {hdr_TDATA, hdr_TKEEP, hdr_TLAST, dest_q, id_q, user_q};

  axis_skid_reg #(.WIDTH(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (hdr_TVALID && (state == BODY)),
    .in_ready  (skid_in_ready),
    .in_data   (in_payload),
    .out_valid (sides_TVALID),
    .out_ready (sides_TREADY),
    .out_data  (out_payload)
  );

  assign {sides_TDATA, sides_TKEEP, sides_TLAST, sides_TDEST, sides_TID, sides_TUSER} = out_payload;

`ifdef AXIS_DEHEADERIZER_ERR_CNT_EN
  logic empty_hdr;
  assign empty_hdr = (state == HDR) && accept && hdr_TLAST;

  always_ff @(posedge clk) begin
    if (rst)                                err_cnt <= '0;
    else if (empty_hdr && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_axis_deheaderizer.sv
// Directed bench for axis_deheaderizer: header stripping, sideband replay,
// back-pressure, empty headers and mid-packet reset.
module tb_axis_deheaderizer;
  import axis_deheaderizer_pkg::*;

  localparam int W = 64 + 8 + 1 + 16 + 16 + 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] hdr_TDATA = '0;
  logic        hdr_TVALID = 1'b0;
  logic        hdr_TREADY;
  logic [7:0]  hdr_TKEEP = '0;
  logic        hdr_TLAST = 1'b0;
  logic [63:0] sides_TDATA;
  logic        sides_TVALID;
  logic        sides_TREADY = 1'b1;
  logic [7:0]  sides_TKEEP;
  logic        sides_TLAST;
  logic [15:0] sides_TDEST;
  logic [15:0] sides_TID;
  logic [7:0]  sides_TUSER;
  state_t      dbg_state;
`ifdef AXIS_DEHEADERIZER_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  axis_deheaderizer dut (
    .clk          (clk),
    .rst          (rst),
    .hdr_TDATA    (hdr_TDATA),
    .hdr_TVALID   (hdr_TVALID),
    .hdr_TREADY   (hdr_TREADY),
    .hdr_TKEEP    (hdr_TKEEP),
    .hdr_TLAST    (hdr_TLAST),
    .sides_TDATA  (sides_TDATA),
    .sides_TVALID (sides_TVALID),
    .sides_TREADY (sides_TREADY),
    .sides_TKEEP  (sides_TKEEP),
    .sides_TLAST  (sides_TLAST),
    .sides_TDEST  (sides_TDEST),
    .sides_TID    (sides_TID),
    .sides_TUSER  (sides_TUSER),
`ifdef AXIS_DEHEADERIZER_ERR_CNT_EN
    .err_cnt      (err_cnt),
`endif
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int out_cnt = 0;
  logic [W-1:0] exp_q[$];

  // Reference model of the packet parser
  bit          m_body = 1'b0;
  logic [15:0] m_dest = '0;
  logic [15:0] m_id = '0;
  logic [7:0]  m_user = '0;
  bit          rnd_ready = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
    bit acc;
    acc = 1'b0;
    hdr_TDATA = d; hdr_TKEEP = k; hdr_TLAST = l; hdr_TVALID = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      if (rnd_ready) sides_TREADY = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = hdr_TREADY;
      @(posedge clk);
      #1;
    end
    hdr_TVALID = 1'b0;
    check("send_accept", acc, 1);
    if (acc) begin
      if (!m_body) begin
        if (!l) begin
          m_body = 1'b1;
          m_dest = d[15:0];
          m_id   = d[31:16];
          m_user = d[39:32];
        end
      end else begin
        exp_q.push_back({d, k, l, m_dest, m_id, m_user});
        if (l) m_body = 1'b0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
      if (rnd_ready) sides_TREADY = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    rnd_ready = 1'b0;
    sides_TREADY = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Output scoreboard and stall-stability monitor
  logic [W-1:0] prev_pl;
  bit           prev_stall = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] obs;
    obs = {sides_TDATA, sides_TKEEP, sides_TLAST, sides_TDEST, sides_TID, sides_TUSER};
    if (prev_stall) begin
      check("out_stable_valid", sides_TVALID, 1);
      check("out_stable_payload", obs, prev_pl);
    end
    if (sides_TVALID && sides_TREADY && !rst) begin
      out_cnt++;
      check("out_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("out_payload", obs, exp_q.pop_front());
    end
    prev_stall = sides_TVALID && !sides_TREADY && !rst;
    prev_pl = obs;
  end

  initial begin
    // Reset
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_tready", hdr_TREADY, 0);
    check("rst_tvalid", sides_TVALID, 0);
    check("rst_tdata", sides_TDATA, 0);
    check("rst_tdest", sides_TDEST, 0);
    check("rst_state", dbg_state, HDR);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("post_rst_tready", hdr_TREADY, 1);

    // Basic packet: header then 1,2,3
    send(64'h0000_00AB_1234_5678, 8'hFF, 1'b0);
    check("hdr_no_out", sides_TVALID, 0);
    check("hdr_state_body", dbg_state, BODY);
    send(64'd1, 8'hFF, 1'b0);
    check("first_latency", sides_TVALID, 1);
    check("first_data", sides_TDATA, 64'd1);
    check("first_dest", sides_TDEST, 16'h5678);
    check("first_id", sides_TID, 16'h1234);
    check("first_user", sides_TUSER, 8'hAB);
    send(64'd2, 8'hFF, 1'b0);
    send(64'd3, 8'h0F, 1'b1);
    check("pkt1_state_hdr", dbg_state, HDR);
    drain();

    // Empty-packet header then a 2-flit packet
    send(64'h0000_00EE_DDDD_CCCC, 8'hFF, 1'b1);
    check("empty_state_hdr", dbg_state, HDR);
    @(posedge clk); #1;
    check("empty_no_out", sides_TVALID, 0);
`ifdef AXIS_DEHEADERIZER_ERR_CNT_EN
    check("err_cnt_one", err_cnt, 16'd1);
`endif
    send(64'h0000_0033_2222_1111, 8'hFF, 1'b0);
    send(64'hA5A5_0000_0000_0001, 8'hFF, 1'b0);
    send(64'hA5A5_0000_0000_0002, 8'h03, 1'b1);
    drain();
    check("pkt2_dest", sides_TDEST, 16'h1111);
    check("pkt2_user", sides_TUSER, 8'h33);

    // Output stalled for 10 cycles mid-body
    send(64'h0000_0044_5555_6666, 8'hFF, 1'b0);
    sides_TREADY = 1'b0;
    send(64'hAAAA, 8'hFF, 1'b0);
    send(64'hBBBB, 8'hFF, 1'b0);
    check("stall_tready_low", hdr_TREADY, 0);
    repeat (10) @(posedge clk);
    #1;
    check("stall_tready_held", hdr_TREADY, 0);
    check("stall_data_held", sides_TDATA, 64'hAAAA);
    sides_TREADY = 1'b1;
    send(64'hCCCC, 8'hFF, 1'b1);
    drain();

    // Back-to-back packets with random output back-pressure
    rnd_ready = 1'b1;
    send(64'h0000_00CC_BBBB_AAAA, 8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) send(64'h1000 + 64'(i), 8'hFF, 1'(i == 3));
    send(64'h0000_0003_0202_0101, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) send(64'h2000 + 64'(i), 8'h3F, 1'(i == 2));
    drain();

    // Reset mid-packet with two body flits buffered
    sides_TREADY = 1'b0;
    send(64'h0000_0077_8888_9999, 8'hFF, 1'b0);
    send(64'hD1, 8'hFF, 1'b0);
    send(64'hD2, 8'hFF, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_tvalid", sides_TVALID, 0);
    check("midrst_tready", hdr_TREADY, 0);
    check("midrst_state", dbg_state, HDR);
    exp_q.delete();
    m_body = 1'b0;
    rst = 1'b0;
    sides_TREADY = 1'b1;
    send(64'h0000_0011_0022_0033, 8'hFF, 1'b0);
    check("post_rst_hdr_state", dbg_state, BODY);
    check("post_rst_no_out", sides_TVALID, 0);
    send(64'h99, 8'h0F, 1'b1);
    check("post_rst_dest", sides_TDEST, 16'h0033);
    check("post_rst_id", sides_TID, 16'h0022);
    check("post_rst_user", sides_TUSER, 8'h11);
    check("post_rst_data", sides_TDATA, 64'h99);
    drain();

    check("total_out", out_cnt, 16);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
